rr_grant_scheduler: RTL and testbench
=====================================

# rr_grant_scheduler

Round-robin scheduler that shares one 16-way select resource among 16 requesters. Each cycle it picks at most one owner, registers the owner index and drives the one-hot grant through the team's 4-to-16 decoder. Holders keep the grant until they release it or hit a hold limit. The block sits in front of any 16-slot shared datapath (bus, memory port, output mux) that is selected by a decoded 4-bit index.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one holder keeps the grant while others wait. Range 0..255; 0 disables preemption.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when high, new grants may be issued.
- `req` in 16: request vector; bit i is requester i.
- `grant` out 16: one-hot grant, all zero when `grant_valid` is low.
- `grant_idx` out 4: index of the current holder.
- `grant_valid` out 1: a holder exists.

## Operation
- State `IDLE`: no holder; `grant_valid`=0.
- State `BUSY`: holder is `grant_idx`; `grant_valid`=1.
- Pointer `ptr` (4 bits) holds the last grantee. Search order is `ptr+1`, `ptr+2`, … `ptr+16`, all mod 16 (wraps 15→0). The first set candidate bit wins.
- `hold_cnt` (8 bits) counts cycles the current holder has been granted.
- `IDLE`→`BUSY`: `enable`=1 and `req`≠0. Winner found by search; `grant_idx`←winner, `ptr`←winner, `hold_cnt`←0.
- `BUSY`, release: `req[grant_idx]`=0 at the edge.
  - If `enable`=1 and another req is set, re-arbitrate in the same edge; the released bit is excluded because its req is 0.
  - Otherwise go to `IDLE`.
- `BUSY`, preempt: `HOLD_MAX`≠0, `hold_cnt`=`HOLD_MAX`−1, `enable`=1 and some other req bit is set. Re-arbitrate with the holder's bit masked; holder loses grant.
- `BUSY`, no other requester at limit: holder keeps grant; `hold_cnt` saturates at `HOLD_MAX`−1.
- `BUSY`, otherwise: hold, `hold_cnt`+1.
- `enable`=0: no new grants and no preemption. An existing holder keeps the grant until release, then the block goes to `IDLE`.
- `grant` = decode(`grant_idx`) gated by `grant_valid` (decoder enable).
- Reset, any cycle: state `IDLE`, `grant`=0, `grant_idx`=0, `grant_valid`=0, `ptr`=15 (first search starts at 0), `hold_cnt`=0. An in-flight grant is dropped immediately and asynchronously.

## Timing
- All state is registered. Outputs change only after a rising edge, or asynchronously on reset.
- Request-to-grant latency: 1 cycle. `req` sampled high at edge N gives `grant` valid after edge N.
- Handoff on release is zero-gap: the next owner is visible in the cycle right after the release edge.
- Preemption: the holder owns exactly `HOLD_MAX` cycles; the new owner is visible in cycle `HOLD_MAX`+1.
- A requester dropping and re-raising req in the same cycle is indistinguishable from holding.
- A requester that drops req while not granted is simply not selected. There is no queuing.
- Combinational path from `req`/`enable` to outputs: none.

## Structure
- Shared package constants:
  - `NUM_REQ`=16
  - `IDX_W`=4
  - `CNT_W`=8
  - state enum `IDLE`/`BUSY`
- Sub-module: `four_input_decoder` (4-to-16, two enabled 3-to-8 halves) converts `grant_idx` to `grant`.
  - Enable gating by `grant_valid` is applied at its output.
- The rotate-and-priority search is a function in the block, not a separate module.

## Test plan
- Reset and basic grant: reset with `req`=0x0000 → all outputs 0. `req`=0x0001 at edge 1 → `grant`=0x0001, `grant_idx`=0 after edge 1.
- Round robin with wrap: `req`=0x8003, each holder releases after 1 cycle → order 0, 1, 15, then 0 again.
- Zero-gap handoff: holder 4 releases while `req[9]`=1 → `grant`=0x0200 in the next cycle, with no idle cycle.
- Preemption, `HOLD_MAX`=3: `req`=0x0041 held constant → 0 owns 3 cycles, 6 owns 3, then 0.
  - `req`=0x0001 alone → 0 held indefinitely.
- Enable gating: `enable`=0 with `req`=0x00F0 → no grant.
  - Raising `enable` → `grant`=0x0010 one cycle later.
  - Dropping `enable` mid-hold → holder 4 keeps grant past `HOLD_MAX` until release, then `IDLE`.
- Reset mid-operation: assert `rst_n`=0 between edges while `grant`=0x0400 → `grant`=0 immediately.
  - After release with `req`=0xFFFF → first grant is index 0.

Source files
------------

// File: rtl/rr_grant_scheduler_pkg.sv
// Shared constants and types for the round-robin grant scheduler.
// Sizes: 16 requesters, 4-bit owner index, 8-bit hold counter.
package rr_grant_scheduler_pkg;

   localparam int NUM_REQ = 16;
   localparam int IDX_W   = 4;
   localparam int CNT_W   = 8;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between requesters and the scheduler.
// master: drives enable/req, sees grant/grant_idx/grant_valid.
// slave : the scheduler side.
interface rr_grant_scheduler_if;
   import rr_grant_scheduler_pkg::*;

   logic               enable;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_valid;

   modport master (
      output enable,
      output req,
      input  grant,
      input  grant_idx,
      input  grant_valid
   );

   modport slave (
      input  enable,
      input  req,
      output grant,
      output grant_idx,
      output grant_valid
   );

endinterface

// File: rtl/rr_grant_scheduler_decoder.sv
// 4-to-16 one-hot decoder built from two 3-to-8 halves.
// Ports: idx (4b select), en (output gate), y (16b one-hot).
module four_input_decoder
   import rr_grant_scheduler_pkg::*;
(
   input  logic [IDX_W-1:0]   idx,
   input  logic               en,
   output logic [NUM_REQ-1:0] y
);

   logic [7:0] lo;
   logic [7:0] hi;

   function automatic logic [7:0] dec3(
      input logic [2:0] a,
      input logic       e
   );
      return e ? (8'd1 << a) : 8'd0;
   endfunction

   // idx[3] selects which half is enabled.
   always_comb begin
      lo = dec3(idx[2:0], ~idx[3]);
      hi = dec3(idx[2:0], idx[3]);
      y  = en ? {hi, lo} : '0;
   end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner select for a 16-slot shared resource.
// Ports: clk, rst_n (async low), bus (slave: enable/req in, grant out).
module rr_grant_scheduler
   import rr_grant_scheduler_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 8
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   rr_grant_scheduler_if.slave  bus
);

   localparam bit PREEMPT_EN = (HOLD_MAX != 0);
   localparam logic [CNT_W-1:0] LIMIT =
      (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] others;
   logic [IDX_W:0]     pick_all;
   logic [IDX_W:0]     pick_oth;
   logic               held;
   logic               at_limit;

   // Search last+1 .. last+16 (mod 16); MSB of result flags a hit.
   // Scanning from the far end lets the nearest candidate win.
   function automatic logic [IDX_W:0] rr_pick(
      input logic [NUM_REQ-1:0] vec,
      input logic [IDX_W-1:0]   last
   );
      logic [IDX_W:0]   res;
      logic [IDX_W-1:0] cand;
      res = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = last + IDX_W'(i);
         if (vec[cand]) res = {1'b1, cand};
      end
      return res;
   endfunction

   always_comb begin
      others   = bus.req & ~(NUM_REQ'(1) << idx_q);
      pick_all = rr_pick(bus.req, ptr_q);
      pick_oth = rr_pick(others, ptr_q);
      held     = bus.req[idx_q];
      at_limit = PREEMPT_EN && (cnt_q == LIMIT);

      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.enable && pick_all[IDX_W]) begin
               state_d = BUSY;
               idx_d   = pick_all[IDX_W-1:0];
               ptr_d   = pick_all[IDX_W-1:0];
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (!held) begin
               // Released bit is already 0 in req, so the
               // masked search is equivalent here.
               if (bus.enable && pick_oth[IDX_W]) begin
                  idx_d = pick_oth[IDX_W-1:0];
                  ptr_d = pick_oth[IDX_W-1:0];
                  cnt_d = '0;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else if (at_limit) begin
               // Preempt only if someone else waits; otherwise
               // the counter just sits at the limit.
               if (bus.enable && pick_oth[IDX_W]) begin
                  idx_d = pick_oth[IDX_W-1:0];
                  ptr_d = pick_oth[IDX_W-1:0];
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ptr_q   <= '1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.grant_valid = (state_q == BUSY);
   assign bus.grant_idx   = idx_q;

   four_input_decoder u_dec (
      .idx (idx_q),
      .en  (state_q == BUSY),
      .y   (bus.grant)
   );

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler with HOLD_MAX=3.
// Directed scenarios plus random traffic against a behavioural model.
module tb_rr_grant_scheduler;

   localparam int HOLD = 3;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // reference model state
   bit   m_valid;
   int   m_idx;
   int   m_ptr;
   int   m_owned;

   rr_grant_scheduler_if bus ();

   rr_grant_scheduler #(.HOLD_MAX(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [15:0] v, input int from);
      for (int k = 1; k <= 16; k++) begin
         if (v[(from + k) % 16]) return (from + k) % 16;
      end
      return -1;
   endfunction

   function automatic logic [15:0] exp_grant();
      logic [15:0] g;
      g = '0;
      if (m_valid) g[m_idx] = 1'b1;
      return g;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_idx   = 0;
      m_ptr   = 15;
      m_owned = 0;
   endtask

   task automatic give(input int w);
      m_valid = 1;
      m_idx   = w;
      m_ptr   = w;
      m_owned = 1;
   endtask

   task automatic model_step(input logic [15:0] r, input logic e);
      logic [15:0] oth;
      if (!m_valid) begin
         if (e && r != 0) give(pick(r, m_ptr));
      end else begin
         oth = r;
         oth[m_idx] = 1'b0;
         if (!r[m_idx]) begin
            if (e && oth != 0) give(pick(oth, m_ptr));
            else m_valid = 0;
         end else if (HOLD > 0 && m_owned >= HOLD && e && oth != 0) begin
            give(pick(oth, m_ptr));
         end else begin
            m_owned++;
         end
      end
   endtask

   task automatic tick(input logic [15:0] r, input logic e);
      bus.req    = r;
      bus.enable = e;
      @(posedge clk);
      model_step(r, e);
      #1;
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      bus.req    = '0;
      bus.enable = 1'b0;
      #2;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      bus.req    = '0;
      bus.enable = 1'b0;
      model_reset();
      #2;
      total++;
      if (bus.grant !== 16'h0000) begin
         bad++;
         $display("FAIL reset_grant: got %h want 0000", bus.grant);
      end
      total++;
      if (bus.grant_idx !== 4'd0) begin
         bad++;
         $display("FAIL reset_idx: got %0d want 0", bus.grant_idx);
      end
      total++;
      if (bus.grant_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid: got %b want 0", bus.grant_valid);
      end
      #1 rst_n = 1'b1;
      tick(16'h0001, 1'b1);
      total++;
      if (bus.grant !== 16'h0001 || bus.grant_idx !== 4'd0 ||
          bus.grant_valid !== 1'b1) begin
         bad++;
         $display("FAIL first_grant: got %h/%0d/%b want 0001/0/1",
                  bus.grant, bus.grant_idx, bus.grant_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [15:0] reqs [4];
      int          want [4];
      logic [15:0] g;
      reqs = '{16'h8003, 16'h8002, 16'h8001, 16'h0003};
      want = '{0, 1, 15, 0};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         tick(reqs[i], 1'b1);
         g = '0;
         g[want[i]] = 1'b1;
         total++;
         if (bus.grant !== g || bus.grant_idx !== 4'(want[i]) ||
             bus.grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL rr_order[%0d]: got %h/%0d want %h/%0d",
                     i, bus.grant, bus.grant_idx, g, want[i]);
         end
      end
   endtask

   task automatic test_handoff();
      tick(16'h0000, 1'b1);
      tick(16'h0010, 1'b1);
      total++;
      if (bus.grant !== 16'h0010) begin
         bad++;
         $display("FAIL handoff_own4: got %h want 0010", bus.grant);
      end
      tick(16'h0210, 1'b1);
      total++;
      if (bus.grant !== 16'h0010) begin
         bad++;
         $display("FAIL handoff_hold4: got %h want 0010", bus.grant);
      end
      tick(16'h0200, 1'b1);
      total++;
      if (bus.grant !== 16'h0200 || bus.grant_valid !== 1'b1) begin
         bad++;
         $display("FAIL handoff_zero_gap: got %h/%b want 0200/1",
                  bus.grant, bus.grant_valid);
      end
   endtask

   task automatic test_preempt();
      int want [10];
      want = '{0, 0, 0, 6, 6, 6, 0, 0, 0, 6};
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         tick(16'h0041, 1'b1);
         total++;
         if (bus.grant_idx !== 4'(want[i]) || bus.grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL preempt_seq[%0d]: got %0d/%b want %0d/1",
                     i, bus.grant_idx, bus.grant_valid, want[i]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         tick(16'h0001, 1'b1);
         total++;
         if (bus.grant !== 16'h0001) begin
            bad++;
            $display("FAIL sole_holder[%0d]: got %h want 0001",
                     i, bus.grant);
         end
      end
   endtask

   task automatic test_enable();
      tick(16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick(16'h00F0, 1'b0);
         total++;
         if (bus.grant !== 16'h0000 || bus.grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL en_off[%0d]: got %h/%b want 0000/0",
                     i, bus.grant, bus.grant_valid);
         end
      end
      tick(16'h00F0, 1'b1);
      total++;
      if (bus.grant !== 16'h0010) begin
         bad++;
         $display("FAIL en_raise: got %h want 0010", bus.grant);
      end
      for (int i = 0; i < 6; i++) begin
         tick(16'h00F0, 1'b0);
         total++;
         if (bus.grant !== 16'h0010) begin
            bad++;
            $display("FAIL en_hold[%0d]: got %h want 0010", i, bus.grant);
         end
      end
      tick(16'h00E0, 1'b0);
      total++;
      if (bus.grant !== 16'h0000 || bus.grant_valid !== 1'b0) begin
         bad++;
         $display("FAIL en_release_idle: got %h/%b want 0000/0",
                  bus.grant, bus.grant_valid);
      end
   endtask

   task automatic test_reset_mid();
      tick(16'h0000, 1'b1);
      tick(16'h0400, 1'b1);
      total++;
      if (bus.grant !== 16'h0400) begin
         bad++;
         $display("FAIL mid_setup: got %h want 0400", bus.grant);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.grant !== 16'h0000 || bus.grant_valid !== 1'b0 ||
          bus.grant_idx !== 4'd0) begin
         bad++;
         $display("FAIL mid_async_drop: got %h/%b/%0d want 0000/0/0",
                  bus.grant, bus.grant_valid, bus.grant_idx);
      end
      model_reset();
      bus.req = 16'hFFFF;
      #1 rst_n = 1'b1;
      tick(16'hFFFF, 1'b1);
      total++;
      if (bus.grant_idx !== 4'd0 || bus.grant !== 16'h0001) begin
         bad++;
         $display("FAIL mid_first_after: got %0d/%h want 0/0001",
                  bus.grant_idx, bus.grant);
      end
   endtask

   task automatic test_random();
      logic [15:0] r;
      logic        e;
      logic [15:0] g;
      apply_reset();
      r = 16'($urandom);
      for (int i = 0; i < 400; i++) begin
         r = r ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
         e = ($urandom_range(0, 9) != 0);
         tick(r, e);
         g = exp_grant();
         total++;
         if (bus.grant !== g || bus.grant_idx !== 4'(m_idx) ||
             bus.grant_valid !== m_valid) begin
            bad++;
            $display("FAIL random[%0d]: got %h/%0d/%b want %h/%0d/%b",
                     i, bus.grant, bus.grant_idx, bus.grant_valid,
                     g, m_idx, m_valid);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_round_robin();
      test_handoff();
      test_preempt();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
